// File: rtl/sig_param_pkg.sv
// Shared definitions for the signal-processing DMA control/status block:
// register word offsets inside a slot, slot/word field widths, the per-channel
// transfer state and the STATUS bit positions.
package sig_param_pkg;

  localparam int WORD_W = 3;

  // Channel slot words
  localparam logic [WORD_W-1:0] W_CTRL   = 3'd0;
  localparam logic [WORD_W-1:0] W_SRC    = 3'd1;
  localparam logic [WORD_W-1:0] W_DST    = 3'd2;
  localparam logic [WORD_W-1:0] W_LEN    = 3'd3;
  localparam logic [WORD_W-1:0] W_STATUS = 3'd4;

  // Global slot words
  localparam logic [WORD_W-1:0] W_PEND = 3'd0;
  localparam logic [WORD_W-1:0] W_MASK = 3'd1;
  localparam logic [WORD_W-1:0] W_ID   = 3'd2;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  // STATUS read bits
  localparam int STAT_REQ      = 0;
  localparam int STAT_BUSY     = 1;
  localparam int STAT_ERR_BUSY = 2;
  localparam int STAT_ERR_ZERO = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } chan_state_e;

endpackage

// File: rtl/sig_param_chan.sv
// One DMA channel: SRC/DST/LEN registers, request/busy FSM and error flags.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   wr_ctrl/wr_src/wr_dst/wr_len decoded write strobes for this channel
//   wdata[31:0]                 bus write data
//   start_ack, done             engine handshake pulses
//   src_addr, dst_addr, len     register outputs to the engine
//   start_req                   level request, high exactly in REQ
//   status[3:0]                 {err_zero, err_busy, busy, req}
//   pend_set                    done/error event, same edge as the FSM update
module sig_param_chan
  import sig_param_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_ctrl,
  input  logic              wr_src,
  input  logic              wr_dst,
  input  logic              wr_len,
  input  logic [31:0]       wdata,
  input  logic              start_ack,
  input  logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [LEN_W-1:0]  len,
  output logic              start_req,
  output logic [3:0]        status,
  output logic              pend_set
);

  chan_state_e state;
  logic        busy;
  logic        err_busy;
  logic        err_zero;
  logic        start_wr;

  assign start_wr = wr_ctrl && wdata[CTRL_START];

  // The interrupt event fires on the same edge that retires the transfer or
  // records a zero-length start.
  assign pend_set = ((state == ST_BUSY) && done) ||
                    ((state == ST_REQ) && start_ack && done) ||
                    ((state == ST_IDLE) && start_wr && (len == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      start_req <= 1'b0;
      busy      <= 1'b0;
      err_busy  <= 1'b0;
      err_zero  <= 1'b0;
      src_addr  <= '0;
      dst_addr  <= '0;
      len       <= '0;
    end else begin
      // Clear comes first so an error raised in the same cycle survives.
      if (wr_ctrl && wdata[CTRL_CLR]) begin
        err_busy <= 1'b0;
        err_zero <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (wr_src) src_addr <= wdata[ADDR_W-1:0];
          if (wr_dst) dst_addr <= wdata[ADDR_W-1:0];
          if (wr_len) len      <= wdata[LEN_W-1:0];
          if (start_wr) begin
            if (len != '0) begin
              state     <= ST_REQ;
              start_req <= 1'b1;
            end else begin
              err_zero <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (start_wr) err_busy <= 1'b1;
          if (start_ack) begin
            start_req <= 1'b0;
            if (done) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_BUSY;
              busy  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (start_wr) err_busy <= 1'b1;
          if (done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          start_req <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    status                = '0;
    status[STAT_REQ]      = start_req;
    status[STAT_BUSY]     = busy;
    status[STAT_ERR_BUSY] = err_busy;
    status[STAT_ERR_ZERO] = err_zero;
  end

endmodule

// File: rtl/sig_param_ctrl.sv
// Avalon-MM control/status register block for NUM_CH DMA engines.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   avs_s0_*                    slave bus; reads return data one clock later
//   avm_s0_irq                  registered |(IRQ_PEND & IRQ_MASK)
//   ch_src_addr/ch_dst_addr     packed per-channel addresses, ch0 in LSBs
//   ch_len                      packed per-channel lengths
//   ch_start_req                per-channel level request
//   ch_start_ack, ch_done       per-channel engine pulses
module sig_param_ctrl
  import sig_param_pkg::*;
#(
  parameter int          NUM_CH  = 4,
  parameter int          ADDR_W  = 32,
  parameter int          LEN_W   = 16,
  parameter logic [31:0] VERSION = 32'h0002_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         avs_s0_write,
  input  logic                         avs_s0_read,
  input  logic [$clog2(NUM_CH+1)+2:0]  avs_s0_address,
  input  logic [31:0]                  avs_s0_writedata,
  output logic [31:0]                  avs_s0_readdata,
  output logic                         avs_s0_readdatavalid,
  output logic                         avm_s0_irq,
  output logic [NUM_CH*ADDR_W-1:0]     ch_src_addr,
  output logic [NUM_CH*ADDR_W-1:0]     ch_dst_addr,
  output logic [NUM_CH*LEN_W-1:0]      ch_len,
  output logic [NUM_CH-1:0]            ch_start_req,
  input  logic [NUM_CH-1:0]            ch_start_ack,
  input  logic [NUM_CH-1:0]            ch_done
);

  localparam int SLOT_W = $clog2(NUM_CH+1);

  logic [SLOT_W-1:0] slot;
  logic [WORD_W-1:0] word;
  logic              glb_sel;

  logic [ADDR_W-1:0] src_arr    [NUM_CH];
  logic [ADDR_W-1:0] dst_arr    [NUM_CH];
  logic [LEN_W-1:0]  len_arr    [NUM_CH];
  logic [3:0]        status_arr [NUM_CH];
  logic [NUM_CH-1:0] pend_set;

  logic [NUM_CH-1:0] irq_pend;
  logic [NUM_CH-1:0] irq_mask;
  logic [31:0]       rmux;

  assign slot    = avs_s0_address[SLOT_W+WORD_W-1:WORD_W];
  assign word    = avs_s0_address[WORD_W-1:0];
  assign glb_sel = (slot == SLOT_W'(NUM_CH));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = avs_s0_write && (slot == SLOT_W'(c));

    sig_param_chan #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wr_ctrl   (sel && (word == W_CTRL)),
      .wr_src    (sel && (word == W_SRC)),
      .wr_dst    (sel && (word == W_DST)),
      .wr_len    (sel && (word == W_LEN)),
      .wdata     (avs_s0_writedata),
      .start_ack (ch_start_ack[c]),
      .done      (ch_done[c]),
      .src_addr  (src_arr[c]),
      .dst_addr  (dst_arr[c]),
      .len       (len_arr[c]),
      .start_req (ch_start_req[c]),
      .status    (status_arr[c]),
      .pend_set  (pend_set[c])
    );

    assign ch_src_addr[c*ADDR_W +: ADDR_W] = src_arr[c];
    assign ch_dst_addr[c*ADDR_W +: ADDR_W] = dst_arr[c];
    assign ch_len[c*LEN_W +: LEN_W]        = len_arr[c];
  end

  // Readback built from current register state, so a same-cycle write to the
  // addressed word is not visible until the next read.
  always_comb begin
    rmux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (slot == SLOT_W'(c)) begin
        case (word)
          W_SRC:    rmux = 32'(src_arr[c]);
          W_DST:    rmux = 32'(dst_arr[c]);
          W_LEN:    rmux = 32'(len_arr[c]);
          W_STATUS: rmux = 32'(status_arr[c]);
          default:  rmux = '0;
        endcase
      end
    end
    if (glb_sel) begin
      case (word)
        W_PEND:  rmux = 32'(irq_pend);
        W_MASK:  rmux = 32'(irq_mask);
        W_ID:    rmux = VERSION;
        default: rmux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend             <= '0;
      irq_mask             <= '0;
      avm_s0_irq           <= 1'b0;
      avs_s0_readdata      <= '0;
      avs_s0_readdatavalid <= 1'b0;
    end else begin
      // New events are OR-ed in after the W1C so a set wins a same-cycle clear.
      if (avs_s0_write && glb_sel && (word == W_PEND))
        irq_pend <= (irq_pend & ~avs_s0_writedata[NUM_CH-1:0]) | pend_set;
      else
        irq_pend <= irq_pend | pend_set;
      if (avs_s0_write && glb_sel && (word == W_MASK))
        irq_mask <= avs_s0_writedata[NUM_CH-1:0];
      avm_s0_irq           <= |(irq_pend & irq_mask);
      avs_s0_readdatavalid <= avs_s0_read;
      if (avs_s0_read) avs_s0_readdata <= rmux;
    end
  end

endmodule

// File: tb/tb_sig_param_ctrl.sv
module tb_sig_param_ctrl;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;
  localparam int AW     = 6;
  localparam int GLB    = NUM_CH;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     avs_s0_write = 1'b0;
  logic                     avs_s0_read = 1'b0;
  logic [AW-1:0]            avs_s0_address = '0;
  logic [31:0]              avs_s0_writedata = '0;
  logic [31:0]              avs_s0_readdata;
  logic                     avs_s0_readdatavalid;
  logic                     avm_s0_irq;
  logic [NUM_CH*ADDR_W-1:0] ch_src_addr;
  logic [NUM_CH*ADDR_W-1:0] ch_dst_addr;
  logic [NUM_CH*LEN_W-1:0]  ch_len;
  logic [NUM_CH-1:0]        ch_start_req;
  logic [NUM_CH-1:0]        ch_start_ack = '0;
  logic [NUM_CH-1:0]        ch_done = '0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sig_param_ctrl #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .VERSION (32'h0002_0000)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .avs_s0_write         (avs_s0_write),
    .avs_s0_read          (avs_s0_read),
    .avs_s0_address       (avs_s0_address),
    .avs_s0_writedata     (avs_s0_writedata),
    .avs_s0_readdata      (avs_s0_readdata),
    .avs_s0_readdatavalid (avs_s0_readdatavalid),
    .avm_s0_irq           (avm_s0_irq),
    .ch_src_addr          (ch_src_addr),
    .ch_dst_addr          (ch_dst_addr),
    .ch_len               (ch_len),
    .ch_start_req         (ch_start_req),
    .ch_start_ack         (ch_start_ack),
    .ch_done              (ch_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] adr(input int slot, input int word);
    return AW'(slot * 8 + word);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input int slot, input int word, input logic [31:0] data);
    avs_s0_write     = 1'b1;
    avs_s0_address   = adr(slot, word);
    avs_s0_writedata = data;
    tick();
    avs_s0_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int slot, input int word, input logic [31:0] exp);
    avs_s0_read    = 1'b1;
    avs_s0_address = adr(slot, word);
    tick();
    avs_s0_read = 1'b0;
    chk({tag, "_vld"}, 32'(avs_s0_readdatavalid), 32'd1);
    chk(tag, avs_s0_readdata, exp);
  endtask

  task automatic pulse_ack(input logic [NUM_CH-1:0] v);
    ch_start_ack = v;
    tick();
    ch_start_ack = '0;
  endtask

  task automatic pulse_done(input logic [NUM_CH-1:0] v);
    ch_done = v;
    tick();
    ch_done = '0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_vld", 32'(avs_s0_readdatavalid), 32'd0);
    chk("rst_irq", 32'(avm_s0_irq), 32'd0);
    chk("rst_req", 32'(ch_start_req), 32'd0);
    chk("rst_src", 32'(ch_src_addr != '0), 32'd0);

    // ID readback and single-cycle valid
    rd_chk("id", GLB, 2, 32'h0002_0000);
    tick();
    chk("vld_drop", 32'(avs_s0_readdatavalid), 32'd0);
    for (int c = 0; c < NUM_CH; c++) rd_chk($sformatf("stat_rst%0d", c), c, 4, 32'h0);
    rd_chk("unmapped", GLB, 5, 32'h0);

    // Read and write of the same word in one cycle: read sees the old value
    avs_s0_read      = 1'b1;
    avs_s0_write     = 1'b1;
    avs_s0_address   = adr(0, 1);
    avs_s0_writedata = 32'h0000_0055;
    tick();
    avs_s0_read  = 1'b0;
    avs_s0_write = 1'b0;
    chk("rw_old", avs_s0_readdata, 32'h0);
    rd_chk("rw_new", 0, 1, 32'h0000_0055);

    // Normal transfer on ch1
    bus_wr(1, 1, 32'h1000);
    bus_wr(1, 2, 32'h2000);
    bus_wr(1, 3, 32'd64);
    bus_wr(1, 0, 32'h1);
    chk("ch1_req", 32'(ch_start_req), 32'h2);
    chk("ch1_src", ch_src_addr[63:32], 32'h1000);
    chk("ch1_dst", ch_dst_addr[63:32], 32'h2000);
    chk("ch1_len", 32'(ch_len[31:16]), 32'd64);
    rd_chk("ch1_st_req", 1, 4, 32'h1);
    pulse_ack(4'b0010);
    chk("ch1_req_off", 32'(ch_start_req), 32'h0);
    rd_chk("ch1_st_busy", 1, 4, 32'h2);
    bus_wr(GLB, 1, 32'h2);
    pulse_done(4'b0010);
    chk("irq_lag", 32'(avm_s0_irq), 32'd0);
    tick();
    chk("irq_on", 32'(avm_s0_irq), 32'd1);
    rd_chk("pend_ch1", GLB, 0, 32'h2);
    rd_chk("ch1_st_idle", 1, 4, 32'h0);
    bus_wr(GLB, 0, 32'h2);
    chk("irq_hold", 32'(avm_s0_irq), 32'd1);
    tick();
    chk("irq_off", 32'(avm_s0_irq), 32'd0);
    rd_chk("pend_clr", GLB, 0, 32'h0);

    // Zero-length start on ch0
    bus_wr(0, 0, 32'h1);
    chk("ch0_noreq", 32'(ch_start_req), 32'h0);
    rd_chk("ch0_err_zero", 0, 4, 32'h8);
    rd_chk("pend_ch0", GLB, 0, 32'h1);
    bus_wr(0, 0, 32'h2);
    rd_chk("ch0_err_clr", 0, 4, 32'h0);
    bus_wr(GLB, 0, 32'h1);

    // Start and register write while ch2 is busy
    bus_wr(2, 1, 32'h3000);
    bus_wr(2, 3, 32'd8);
    bus_wr(2, 0, 32'h1);
    pulse_ack(4'b0100);
    rd_chk("ch2_busy", 2, 4, 32'h2);
    bus_wr(2, 1, 32'hDEAD);
    bus_wr(2, 0, 32'h1);
    chk("ch2_src_keep", ch_src_addr[95:64], 32'h3000);
    rd_chk("ch2_err_busy", 2, 4, 32'h6);
    rd_chk("ch2_src_rd", 2, 1, 32'h3000);

    // done3 collides with W1C of bit3; pend is masked off
    bus_wr(3, 3, 32'd4);
    bus_wr(3, 0, 32'h1);
    pulse_ack(4'b1000);
    avs_s0_write     = 1'b1;
    avs_s0_address   = adr(GLB, 0);
    avs_s0_writedata = 32'h8;
    ch_done          = 4'b1000;
    tick();
    avs_s0_write = 1'b0;
    ch_done      = '0;
    rd_chk("pend_set_wins", GLB, 0, 32'h8);
    tick();
    chk("irq_masked", 32'(avm_s0_irq), 32'd0);

    // Reset in the middle of activity
    bus_wr(0, 3, 32'd5);
    bus_wr(0, 0, 32'h1);
    bus_wr(1, 0, 32'h1);
    pulse_ack(4'b0010);
    chk("pre_rst_req", 32'(ch_start_req), 32'h1);
    bus_wr(GLB, 1, 32'h8);
    tick();
    chk("pre_rst_irq", 32'(avm_s0_irq), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_req", 32'(ch_start_req), 32'h0);
    chk("mid_rst_irq", 32'(avm_s0_irq), 32'd0);
    rst = 1'b0;
    rd_chk("post_rst_st0", 0, 4, 32'h0);
    rd_chk("post_rst_st1", 1, 4, 32'h0);
    rd_chk("post_rst_st2", 2, 4, 32'h0);
    rd_chk("post_rst_pend", GLB, 0, 32'h0);
    rd_chk("post_rst_mask", GLB, 1, 32'h0);
    chk("post_rst_len", 32'(ch_len != '0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
